// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI frame-buffer write path: default bus-width
// typedefs and the arbiter FSM state encoding.
package hdmi_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 16;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_DATA_W-1:0] fb_data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : hdmi_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req at or after ptr,
// scanning upward and wrapping back to index 0.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves
  // them unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule : rr_picker

// File: rtl/fb_write_arbiter.sv
// Round-robin burst arbiter merging NREQ pixel writers onto the single HDMI
// frame-buffer write port. Define FB_ARB_VBLANK_ONLY_EN to restrict writes
// to vertical blanking.
module fb_write_arbiter
  import hdmi_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16,
  localparam int IDX_W    = $clog2(NREQ),
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NREQ-1:0][DATA_W-1:0]  data_i,
  output logic [NREQ-1:0]              gnt_o,
  input  logic                         vblank_i,
  output logic [ADDR_W-1:0]            pxl_addr_o,
  output logic [DATA_W-1:0]            pxl_data_o,
  output logic                         pxl_en_o,
  output logic                         busy_o,
  output logic [IDX_W-1:0]             owner_o
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              pxl_en_q, pxl_en_d;
  logic [ADDR_W-1:0] pxl_addr_q, pxl_addr_d;
  logic [DATA_W-1:0] pxl_data_q, pxl_data_d;
  logic              rst_done_q;

  logic              win_open;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [NREQ-1:0]   grant_vec;
  logic              owner_req;
  logic              xfer;
  logic              burst_done;
  logic [IDX_W-1:0]  next_ptr;

`ifdef FB_ARB_VBLANK_ONLY_EN
  assign win_open = vblank_i;
`else
  logic unused_vblank;
  assign unused_vblank = vblank_i;
  assign win_open      = 1'b1;
`endif

  rr_picker #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req   (req_i & {NREQ{win_open}}),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    grant_vec = '0;
    if (state_q == GRANT) grant_vec[owner_q] = 1'b1;
  end

  // Closing the blanking window masks the ready so no beat slips through
  // on the cycle the grant is dropped.
  assign gnt_o      = grant_vec & {NREQ{win_open}};
  assign owner_req  = req_i[owner_q];
  assign xfer       = (state_q == GRANT) && owner_req && win_open;
  assign burst_done = xfer && (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign next_ptr   = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    pxl_en_d   = 1'b0;
    pxl_addr_d = pxl_addr_q;
    pxl_data_d = pxl_data_q;
    case (state_q)
      IDLE: begin
        // rst_done_q holds off the first grant for one edge after reset.
        if (pick_valid && rst_done_q) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          pxl_en_d   = 1'b1;
          pxl_addr_d = addr_i[owner_q];
          pxl_data_d = data_i[owner_q];
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (!owner_req || burst_done || !win_open) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      pxl_en_q   <= 1'b0;
      pxl_addr_q <= '0;
      pxl_data_q <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      pxl_en_q   <= pxl_en_d;
      pxl_addr_q <= pxl_addr_d;
      pxl_data_q <= pxl_data_d;
      rst_done_q <= 1'b1;
    end
  end

  assign pxl_en_o   = pxl_en_q;
  assign pxl_addr_o = pxl_addr_q;
  assign pxl_data_o = pxl_data_q;
  assign busy_o     = (state_q == GRANT);
  assign owner_o    = owner_q;

endmodule : fb_write_arbiter

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a default instance (MAX_BURST=16) and
// a MAX_BURST=1 instance share clock and reset.
module tb_fb_write_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req, req1;
  logic [3:0][16:0] addr;
  logic [3:0][15:0] data;
  logic             vblank;

  logic [3:0]  gnt, gnt1;
  logic [16:0] pxl_addr, pxl_addr1;
  logic [15:0] pxl_data, pxl_data1;
  logic        pxl_en, pxl_en1;
  logic        busy, busy1;
  logic [1:0]  owner, owner1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fb_write_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .addr_i(addr), .data_i(data),
    .gnt_o(gnt), .vblank_i(vblank), .pxl_addr_o(pxl_addr), .pxl_data_o(pxl_data),
    .pxl_en_o(pxl_en), .busy_o(busy), .owner_o(owner)
  );

  fb_write_arbiter #(.MAX_BURST(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .addr_i(addr), .data_i(data),
    .gnt_o(gnt1), .vblank_i(vblank), .pxl_addr_o(pxl_addr1), .pxl_data_o(pxl_data1),
    .pxl_en_o(pxl_en1), .busy_o(busy1), .owner_o(owner1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset, then one edge so the arbiter may grant on the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({gnt, pxl_en, busy, owner, pxl_addr, pxl_data} !== 41'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b en=%b busy=%b owner=%0d addr=%h data=%h, want all zero",
               gnt, pxl_en, busy, owner, pxl_addr, pxl_data);
    end
    req = 4'b0001;
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b0000) begin
      n_err++; $display("FAIL reset_first_edge_gnt: got %b, want 0000", gnt);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_err++; $display("FAIL reset_second_edge_gnt: got gnt=%b busy=%b, want 0001/1", gnt, busy);
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || pxl_en !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_drop_req: got gnt=%b en=%b busy=%b, want 0/0/0", gnt, pxl_en, busy);
    end
  endtask

  task automatic test_rr_burst();
    logic [3:0] exp_gnt;
    logic       exp_en;
    logic [16:0] exp_addr;
    do_reset();
    req = 4'b0101;
    for (int c = 0; c <= 34; c++) begin
      tick();
      if (c <= 15 || c == 34) exp_gnt = 4'b0001;
      else if (c >= 17 && c <= 32) exp_gnt = 4'b0100;
      else exp_gnt = 4'b0000;
      exp_en   = (c >= 1 && c <= 16) || (c >= 18 && c <= 33);
      exp_addr = (c <= 16) ? 17'h00100 : 17'h00200;
      n_vec++;
      if (gnt !== exp_gnt) begin
        n_err++; $display("FAIL rr_burst_gnt c=%0d: got %b, want %b", c, gnt, exp_gnt);
      end
      n_vec++;
      if (pxl_en !== exp_en) begin
        n_err++; $display("FAIL rr_burst_en c=%0d: got %b, want %b", c, pxl_en, exp_en);
      end
      if (exp_en) begin
        n_vec++;
        if (pxl_addr !== exp_addr) begin
          n_err++; $display("FAIL rr_burst_addr c=%0d: got %h, want %h", c, pxl_addr, exp_addr);
        end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_single_beat();
    do_reset();
    req = 4'b0010;
    tick();
    n_vec++;
    if (gnt !== 4'b0010 || pxl_en !== 1'b0 || owner !== 2'd1) begin
      n_err++; $display("FAIL single_grant: got gnt=%b en=%b owner=%0d, want 0010/0/1", gnt, pxl_en, owner);
    end
    tick();
    req = 4'b0000;
    n_vec++;
    if (pxl_en !== 1'b1 || pxl_addr !== 17'h00010 || pxl_data !== 16'hF800) begin
      n_err++; $display("FAIL single_beat_out: got en=%b addr=%h data=%h, want 1/00010/f800", pxl_en, pxl_addr, pxl_data);
    end
    tick();
    n_vec++;
    if (pxl_en !== 1'b0 || pxl_addr !== 17'h00010 || pxl_data !== 16'hF800 || busy !== 1'b0 || gnt !== 4'b0000) begin
      n_err++; $display("FAIL single_after: got en=%b addr=%h data=%h busy=%b gnt=%b, want 0/00010/f800/0/0000",
                        pxl_en, pxl_addr, pxl_data, busy, gnt);
    end
    tick();
    n_vec++;
    if (pxl_en !== 1'b0 || owner !== 2'd1) begin
      n_err++; $display("FAIL single_idle: got en=%b owner=%0d, want 0/1", pxl_en, owner);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_gnt;
    do_reset();
    req1 = 4'b1111;
    for (int c = 0; c <= 9; c++) begin
      tick();
      exp_gnt = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
      n_vec++;
      if (gnt1 !== exp_gnt) begin
        n_err++; $display("FAIL b2b_gnt c=%0d: got %b, want %b", c, gnt1, exp_gnt);
      end
      n_vec++;
      if (pxl_en1 !== (c % 2 == 1)) begin
        n_err++; $display("FAIL b2b_en c=%0d: got %b, want %b", c, pxl_en1, (c % 2 == 1));
      end
    end
    req1 = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c <= 5; c++) tick();
    n_vec++;
    if (pxl_en !== 1'b1 || gnt !== 4'b0100) begin
      n_err++; $display("FAIL midrst_beat5: got en=%b gnt=%b, want 1/0100", pxl_en, gnt);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt, pxl_en, busy, owner, pxl_addr, pxl_data} !== 41'd0) begin
      n_err++; $display("FAIL midrst_async: got gnt=%b en=%b busy=%b owner=%0d addr=%h data=%h, want all zero",
                        gnt, pxl_en, busy, owner, pxl_addr, pxl_data);
    end
    req = 4'b0101;
    tick();
    n_vec++;
    if (pxl_en !== 1'b0 || gnt !== 4'b0000) begin
      n_err++; $display("FAIL midrst_held: got en=%b gnt=%b, want 0/0000", pxl_en, gnt);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || pxl_en !== 1'b0) begin
      n_err++; $display("FAIL midrst_edge1: got gnt=%b en=%b, want 0000/0", gnt, pxl_en);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0001 || owner !== 2'd0 || pxl_en !== 1'b0) begin
      n_err++; $display("FAIL midrst_regrant: got gnt=%b owner=%0d en=%b, want 0001/0/0", gnt, owner, pxl_en);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_vblank();
    int pulses;
    do_reset();
    vblank = 1'b0;
    req = 4'b1000;
`ifdef FB_ARB_VBLANK_ONLY_EN
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_err++; $display("FAIL vblank_blocked c=%0d: got gnt=%b busy=%b, want 0000/0", c, gnt, busy);
      end
    end
    vblank = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      n_err++; $display("FAIL vblank_grant: got gnt=%b owner=%0d, want 1000/3", gnt, owner);
    end
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (pxl_en === 1'b1) pulses++;
    end
    vblank = 1'b0;
    #1;
    n_vec++;
    if (gnt !== 4'b0000) begin
      n_err++; $display("FAIL vblank_gnt_mask: got %b, want 0000", gnt);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (pxl_en === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 3) begin
      n_err++; $display("FAIL vblank_pulses: got %0d, want 3", pulses);
    end
    n_vec++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      n_err++; $display("FAIL vblank_idle: got busy=%b gnt=%b, want 0/0000", busy, gnt);
    end
`else
    tick();
    n_vec++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      n_err++; $display("FAIL vblank_ignored: got gnt=%b owner=%0d, want 1000/3", gnt, owner);
    end
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (pxl_en === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 3) begin
      n_err++; $display("FAIL vblank_ignored_pulses: got %0d, want 3", pulses);
    end
`endif
    req = 4'b0000;
    vblank = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    req1   = '0;
    vblank = 1'b1;
    addr   = '0;
    data   = '0;
    addr[0] = 17'h00100; data[0] = 16'h1111;
    addr[1] = 17'h00010; data[1] = 16'hF800;
    addr[2] = 17'h00200; data[2] = 16'h2222;
    addr[3] = 17'h00300; data[3] = 16'h3333;

    test_reset();
    test_rr_burst();
    test_single_beat();
    test_back_to_back();
    test_reset_mid_burst();
    test_vblank();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fb_write_arbiter
